// File: rtl/pll_drp_reconfig_if.sv
// PLLE2_ADV DRP bus bundle (DCLK is the controller clock, not carried here).
// Latency: n/a (wires only).
// Backpressure: the slave holds off the master by delaying drp_drdy.
// Ports (master view): drp_den/drp_dwe strobes, drp_daddr[6:0], drp_di[15:0] out;
//                      drp_do[15:0], drp_drdy in.
interface pll_drp_reconfig_if;
    logic        drp_den;
    logic        drp_dwe;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_drdy;

    modport master (
        output drp_den, drp_dwe, drp_daddr, drp_di,
        input  drp_do, drp_drdy
    );

    modport slave (
        input  drp_den, drp_dwe, drp_daddr, drp_di,
        output drp_do, drp_drdy
    );
endinterface

// File: rtl/pll_drp_reconfig.sv
// PLLE2_ADV reconfiguration sequencer: boot reset/lock, then per request RMW of a register table over DRP.
// Latency: RST_HOLD cycles of PLL reset, then one read + one write per entry (each waits for DRDY), then LOCKED.
// Backpressure: cfg_req is ignored while busy; each DRP access waits on drp_drdy, bounded by LOCK_TIMEOUT.
// Ports: clk100 (also DCLK), cpu_reset (sync, active high), cfg_req/cfg_sel request,
//        busy/done/error/cur_cfg/locked status, pll_rst/pll_locked to the PLL, drp bus (master modport).
// Optional: define PLL_DRP_READBACK_EN to re-read and verify every written register.
module pll_drp_reconfig #(
    parameter int                      NUM_REGS     = 4,
    parameter logic [NUM_REGS*39-1:0]  CFG0_TABLE   = '0,
    parameter logic [NUM_REGS*39-1:0]  CFG1_TABLE   = '0,
    parameter int                      RST_HOLD     = 8,
    parameter int                      LOCK_TIMEOUT = 50000
) (
    input  logic                       clk100,
    input  logic                       cpu_reset,
    input  logic                       cfg_req,
    input  logic                       cfg_sel,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic                       cur_cfg,
    output logic                       locked,
    output logic                       pll_rst,
    input  logic                       pll_locked,
    pll_drp_reconfig_if.master         drp
);

    typedef enum logic [3:0] {
        S_BOOT_RST, S_IDLE, S_ASSERT_RST, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT,
        S_VRD, S_VRD_WAIT, S_RELEASE, S_LOCK_WAIT
    } state_t;

    localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD - 1);
    localparam logic [15:0] TMO_LAST  = 16'(LOCK_TIMEOUT - 1);
    localparam logic [2:0]  IDX_LAST  = 3'(NUM_REGS - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic        sel_q, sel_d;
    logic        boot_q, boot_d;
    logic        lock_m_q, lock_s_q;
    logic        done_evt, err_evt;
    logic [38:0] ent;

    logic        busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic        cur_cfg_q, cur_cfg_d, locked_q, locked_d, pll_rst_q, pll_rst_d;
    logic        den_q, den_d, dwe_q, dwe_d;
    logic [6:0]  daddr_q, daddr_d;
    logic [15:0] di_q, di_d;

    // Table entry {addr, mask, data} for a given configuration and index.
    function automatic logic [38:0] entry(input logic sel, input logic [2:0] idx);
        logic [38:0] e;
        e = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (k == int'(idx)) begin
                e = sel ? CFG1_TABLE[k*39 +: 39] : CFG0_TABLE[k*39 +: 39];
            end
        end
        return e;
    endfunction

    // State register and datapath flops.
    always_ff @(posedge clk100) begin
        if (cpu_reset) begin
            state_q   <= S_BOOT_RST;
            cnt_q     <= '0;
            idx_q     <= '0;
            sel_q     <= 1'b0;
            boot_q    <= 1'b1;
            lock_m_q  <= 1'b0;
            lock_s_q  <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            cur_cfg_q <= 1'b0;
            locked_q  <= 1'b0;
            pll_rst_q <= 1'b1;
            den_q     <= 1'b0;
            dwe_q     <= 1'b0;
            daddr_q   <= '0;
            di_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sel_q     <= sel_d;
            boot_q    <= boot_d;
            lock_m_q  <= pll_locked;
            lock_s_q  <= lock_m_q;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            cur_cfg_q <= cur_cfg_d;
            locked_q  <= locked_d;
            pll_rst_q <= pll_rst_d;
            den_q     <= den_d;
            dwe_q     <= dwe_d;
            daddr_q   <= daddr_d;
            di_q      <= di_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sel_d    = sel_q;
        boot_d   = boot_q;
        done_evt = 1'b0;
        err_evt  = 1'b0;
        case (state_q)
            S_BOOT_RST:   if (cnt_q >= HOLD_LAST) state_d = S_LOCK_WAIT;
            S_IDLE: begin
                if (cfg_req) begin
                    sel_d   = cfg_sel;
                    idx_d   = '0;
                    state_d = S_ASSERT_RST;
                end
            end
            S_ASSERT_RST: if (cnt_q >= HOLD_LAST) state_d = S_RD;
            S_RD:         state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (drp.drp_drdy) begin
                    state_d = S_WR;
                end else if (cnt_q >= TMO_LAST) begin
                    err_evt = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WR:         state_d = S_WR_WAIT;
            S_WR_WAIT: begin
                if (drp.drp_drdy) begin
`ifdef PLL_DRP_READBACK_EN
                    state_d = S_VRD;
`else
                    if (idx_q == IDX_LAST) begin
                        state_d = S_RELEASE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_RD;
                    end
`endif
                end else if (cnt_q >= TMO_LAST) begin
                    err_evt = 1'b1;
                    state_d = S_IDLE;
                end
            end
`ifdef PLL_DRP_READBACK_EN
            S_VRD:        state_d = S_VRD_WAIT;
            S_VRD_WAIT: begin
                if (drp.drp_drdy) begin
                    // di_q still holds the value just written to this address.
                    if ((drp.drp_do ^ di_q) != 16'h0000) begin
                        err_evt = 1'b1;
                        state_d = S_IDLE;
                    end else if (idx_q == IDX_LAST) begin
                        state_d = S_RELEASE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_RD;
                    end
                end else if (cnt_q >= TMO_LAST) begin
                    err_evt = 1'b1;
                    state_d = S_IDLE;
                end
            end
`endif
            S_RELEASE:    state_d = S_LOCK_WAIT;
            S_LOCK_WAIT: begin
                // Lock wins over a timeout landing in the same cycle.
                if (lock_s_q) begin
                    done_evt = 1'b1;
                    boot_d   = 1'b0;
                    state_d  = S_IDLE;
                end else if (cnt_q >= TMO_LAST) begin
                    err_evt  = 1'b1;
                    boot_d   = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default:      state_d = S_BOOT_RST;
        endcase
    end

    // Output / datapath next values; all driven from the upcoming state so outputs line up with it.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q inside {S_BOOT_RST, S_ASSERT_RST, S_RD_WAIT, S_WR_WAIT,
                                     S_VRD_WAIT, S_LOCK_WAIT}) begin
            cnt_d = cnt_q + 16'd1;
        end

        ent       = entry(sel_d, idx_d);
        pll_rst_d = state_d inside {S_BOOT_RST, S_ASSERT_RST, S_RD, S_RD_WAIT, S_WR,
                                    S_WR_WAIT, S_VRD, S_VRD_WAIT};
        busy_d    = (state_d != S_IDLE);
        done_d    = done_evt;
        error_d   = err_evt;
        cur_cfg_d = (done_evt && !boot_q) ? sel_q : cur_cfg_q;
        locked_d  = lock_s_q && (state_d == S_IDLE);
        den_d     = state_d inside {S_RD, S_WR, S_VRD};
        dwe_d     = (state_d == S_WR);
        daddr_d   = den_d ? ent[38:32] : daddr_q;

        // Merge is taken straight off drp_do on the read DRDY; mask bit 1 keeps the PLL's bit.
        di_d = di_q;
        if (state_q == S_RD_WAIT && drp.drp_drdy) begin
            di_d = (drp.drp_do & ent[31:16]) | (ent[15:0] & ~ent[31:16]);
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign cur_cfg       = cur_cfg_q;
    assign locked        = locked_q;
    assign pll_rst       = pll_rst_q;
    assign drp.drp_den   = den_q;
    assign drp.drp_dwe   = dwe_q;
    assign drp.drp_daddr = daddr_q;
    assign drp.drp_di    = di_q;

endmodule

// File: tb/tb_pll_drp_reconfig.sv
// Bench for pll_drp_reconfig: DRP memory responder, PLL lock model, transaction scoreboard.
// Latency: n/a.
// Backpressure: DRP responder answers 2 cycles after each strobe (or never, when told to).
module tb_pll_drp_reconfig;
    localparam int NR   = 4;
    localparam int HOLD = 8;
    localparam int TMO  = 100;
    localparam logic [NR*39-1:0] T0 = {7'h0B, 16'h00FF, 16'h1234, 7'h0A, 16'h0F0F, 16'hBEEF,
                                       7'h09, 16'hFFF0, 16'h0007, 7'h08, 16'h0000, 16'h5A5A};
    localparam logic [NR*39-1:0] T1 = {7'h0F, 16'hFF00, 16'h00C3, 7'h0E, 16'h0000, 16'h8001,
                                       7'h0D, 16'h3C3C, 16'h4242, 7'h0C, 16'hF000, 16'h0105};
    localparam int K_RD = 0, K_WR = 1, K_DONE = 2, K_ERR = 3;

    logic clk100 = 1'b0;
    logic cpu_reset, cfg_req, cfg_sel, pll_locked;
    logic busy, done, error, cur_cfg, locked, pll_rst;

    pll_drp_reconfig_if drp_if ();

    pll_drp_reconfig #(
        .NUM_REGS(NR), .CFG0_TABLE(T0), .CFG1_TABLE(T1),
        .RST_HOLD(HOLD), .LOCK_TIMEOUT(TMO)
    ) dut (
        .clk100(clk100), .cpu_reset(cpu_reset), .cfg_req(cfg_req), .cfg_sel(cfg_sel),
        .busy(busy), .done(done), .error(error), .cur_cfg(cur_cfg), .locked(locked),
        .pll_rst(pll_rst), .pll_locked(pll_locked), .drp(drp_if.master)
    );

    always #5 clk100 = ~clk100;

    typedef struct { int kind; logic [6:0] addr; logic [15:0] dat; } ev_t;
    ev_t exp_q[$];

    int n_chk = 0, n_pass = 0;
    logic [15:0] drp_mem [128];
    logic [15:0] ref_mem [128];
    logic no_drdy = 1'b0, corrupt = 1'b0, hold_low = 1'b0;
    logic exp_cur = 1'b0;
    int t_rel, t_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    endtask

    task automatic push(input int k, input logic [6:0] a, input logic [15:0] d);
        ev_t e;
        e.kind = k; e.addr = a; e.dat = d;
        exp_q.push_back(e);
    endtask

    function automatic logic [38:0] tab_entry(input logic sel, input int i);
        logic [NR*39-1:0] t;
        t = sel ? T1 : T0;
        return t[i*39 +: 39];
    endfunction

    // Reference model: what one request must do, transaction by transaction.
    // mode 0 normal, 1 lock never comes, 2 DRDY never comes, 3 readback corrupted.
    task automatic model_cfg(input logic sel, input int mode);
        logic [38:0] e;
        logic [15:0] wv;
        for (int i = 0; i < NR; i++) begin
            e = tab_entry(sel, i);
            push(K_RD, e[38:32], 16'h0);
            if (mode == 2) begin
                push(K_ERR, 7'h0, 16'h0);
                return;
            end
            wv = (ref_mem[e[38:32]] & e[31:16]) | (e[15:0] & ~e[31:16]);
            push(K_WR, e[38:32], wv);
            ref_mem[e[38:32]] = wv;
`ifdef PLL_DRP_READBACK_EN
            push(K_RD, e[38:32], 16'h0);
            if (mode == 3) begin
                push(K_ERR, 7'h0, 16'h0);
                return;
            end
`endif
        end
        if (mode == 1) push(K_ERR, 7'h0, 16'h0);
        else           push(K_DONE, 7'h0, {15'h0, sel});
    endtask

    // DRP responder: memory with a 2-cycle DRDY; optional silence and bit-3 readback corruption.
    initial begin
        int pend;
        logic [6:0] p_addr, last_wr_addr;
        logic p_we, last_wr_vld;
        logic [15:0] p_di, rd;
        pend = 0; last_wr_vld = 1'b0; last_wr_addr = '0; p_addr = '0; p_we = 1'b0; p_di = '0;
        drp_if.drp_drdy = 1'b0;
        drp_if.drp_do   = 16'h0;
        forever begin
            @(negedge clk100);
            drp_if.drp_drdy = 1'b0;
            if (cpu_reset) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        if (p_we) begin
                            drp_mem[p_addr] = p_di;
                            last_wr_vld = 1'b1;
                            last_wr_addr = p_addr;
                        end else begin
                            rd = drp_mem[p_addr];
                            if (corrupt && last_wr_vld && last_wr_addr == p_addr) rd = rd ^ 16'h0008;
                            drp_if.drp_do = rd;
                            last_wr_vld = 1'b0;
                        end
                        drp_if.drp_drdy = 1'b1;
                    end
                end
                if (drp_if.drp_den) begin
                    p_addr = drp_if.drp_daddr;
                    p_we   = drp_if.drp_dwe;
                    p_di   = drp_if.drp_di;
                    pend   = no_drdy ? 0 : 2;
                end
            end
        end
    end

    // PLL model: LOCKED drops under RST, rises 20 cycles after RST is released.
    initial begin
        int lcnt;
        lcnt = 0;
        pll_locked = 1'b0;
        forever begin
            @(negedge clk100);
            if (pll_rst || cpu_reset) begin
                pll_locked = 1'b0;
                lcnt = 0;
            end else if (!hold_low) begin
                if (lcnt < 20) lcnt++;
                else pll_locked = 1'b1;
            end
        end
    end

    // Monitor: every DRP strobe / done / error is matched against the scoreboard.
    always @(negedge clk100) begin
        ev_t e;
        if (!cpu_reset) begin
            if (drp_if.drp_den) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_drp: addr %0h with nothing expected", drp_if.drp_daddr);
                end else begin
                    e = exp_q.pop_front();
                    chk("drp_kind", drp_if.drp_dwe ? K_WR : K_RD, e.kind);
                    chk("drp_addr", {25'h0, drp_if.drp_daddr}, {25'h0, e.addr});
                    if (e.kind == K_WR) chk("drp_wdata", {16'h0, drp_if.drp_di}, {16'h0, e.dat});
                    chk("pll_rst_during_drp", {31'h0, pll_rst}, 1);
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_done: nothing expected");
                end else begin
                    e = exp_q.pop_front();
                    chk("done_kind", K_DONE, e.kind);
                    chk("done_cur_cfg", {31'h0, cur_cfg}, {16'h0, e.dat});
                end
            end
            if (error) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_error: nothing expected");
                end else begin
                    e = exp_q.pop_front();
                    chk("error_kind", K_ERR, e.kind);
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_pll_rst"}, {31'h0, pll_rst}, 1);
        chk({tag, "_busy"},    {31'h0, busy}, 1);
        chk({tag, "_done"},    {31'h0, done}, 0);
        chk({tag, "_error"},   {31'h0, error}, 0);
        chk({tag, "_cur_cfg"}, {31'h0, cur_cfg}, 0);
        chk({tag, "_locked"},  {31'h0, locked}, 0);
        chk({tag, "_den"},     {31'h0, drp_if.drp_den}, 0);
        chk({tag, "_dwe"},     {31'h0, drp_if.drp_dwe}, 0);
        chk({tag, "_daddr"},   {25'h0, drp_if.drp_daddr}, 0);
        chk({tag, "_di"},      {16'h0, drp_if.drp_di}, 0);
    endtask

    // Called at a negedge with cpu_reset high; releases it and follows the boot sequence.
    task automatic do_boot(input string tag);
        int n, cyc;
        push(K_DONE, 7'h0, 16'h0);
        cpu_reset = 1'b0;
        n = 0;
        for (int k = 0; k < 50; k++) begin
            if (!pll_rst) break;
            n++;
            @(negedge clk100);
        end
        chk({tag, "_rst_len"}, n, HOLD);
        cyc = 0;
        while (busy && cyc < 500) begin
            @(negedge clk100);
            cyc++;
        end
        chk({tag, "_busy_drop"}, {31'h0, busy}, 0);
        @(negedge clk100);
        chk({tag, "_locked"}, {31'h0, locked}, 1);
        chk({tag, "_cur_cfg"}, {31'h0, cur_cfg}, 0);
        chk({tag, "_events_left"}, exp_q.size(), 0);
    endtask

    // Issue one request (plus an ignored one mid-flight) and wait for it to finish.
    task automatic run_cfg(input logic sel, input int mode);
        int cyc;
        logic prev;
        model_cfg(sel, mode);
        @(negedge clk100);
        cfg_sel = sel;
        cfg_req = 1'b1;
        @(negedge clk100);
        cfg_req = 1'b0;
        cyc = 0; t_rel = -1; t_err = -1; prev = pll_rst;
        while (busy && cyc < 3000) begin
            cfg_req = (cyc == 10);
            cfg_sel = (cyc == 10) ? ~sel : sel;
            @(negedge clk100);
            cyc++;
            if (prev && !pll_rst && t_rel < 0) t_rel = cyc;
            if (error && t_err < 0) t_err = cyc;
            prev = pll_rst;
        end
        cfg_req = 1'b0;
        chk("req_busy_drop", {31'h0, busy}, 0);
        @(negedge clk100);
        chk("req_events_left", exp_q.size(), 0);
    endtask

    initial begin
        logic sel;
        logic [38:0] e;
        int cyc;
        logic [15:0] v;
        cpu_reset = 1'b1; cfg_req = 1'b0; cfg_sel = 1'b0;
        for (int a = 0; a < 128; a++) begin
            drp_mem[a] = 16'($urandom);
            ref_mem[a] = drp_mem[a];
        end
        drp_mem[7'h0C] = 16'hA3FF;
        ref_mem[7'h0C] = 16'hA3FF;

        // Boot: reset values, RST hold, lock, idle.
        repeat (3) @(posedge clk100);
        @(negedge clk100);
        check_reset_vals("por");
        do_boot("boot");

        // Directed CFG1 load; first entry merges 0xA3FF into 0xA105.
        run_cfg(1'b1, 0);
        exp_cur = 1'b1;
        chk("cfg1_cur_cfg", {31'h0, cur_cfg}, 1);
        chk("cfg1_reg0c", {16'h0, drp_mem[7'h0C]}, 32'hA105);
        chk("cfg1_locked", {31'h0, locked}, 1);

        // Random configurations against random PLL register contents.
        for (int r = 0; r < 4; r++) begin
            sel = 1'($urandom_range(0, 1));
            for (int i = 0; i < NR; i++) begin
                e = tab_entry(sel, i);
                v = 16'($urandom);
                drp_mem[e[38:32]] = v;
                ref_mem[e[38:32]] = v;
            end
            run_cfg(sel, 0);
            exp_cur = sel;
            chk("rand_cur_cfg", {31'h0, cur_cfg}, {31'h0, exp_cur});
        end

        // LOCKED never returns: error one RELEASE cycle + TMO cycles after RST drops.
        hold_low = 1'b1;
        run_cfg(~exp_cur, 1);
        chk("lock_tmo_cycles", t_err - t_rel, TMO + 1);
        chk("lock_tmo_pll_rst", {31'h0, pll_rst}, 0);
        chk("lock_tmo_cur_cfg", {31'h0, cur_cfg}, {31'h0, exp_cur});
        hold_low = 1'b0;
        repeat (30) @(negedge clk100);

        // DRDY never returns.
        no_drdy = 1'b1;
        sel = 1'($urandom_range(0, 1));
        run_cfg(sel, 2);
        chk("drdy_tmo_pll_rst", {31'h0, pll_rst}, 0);
        chk("drdy_tmo_cur_cfg", {31'h0, cur_cfg}, {31'h0, exp_cur});

        // Retry, then cpu_reset while the read is outstanding.
        e = tab_entry(sel, 0);
        push(K_RD, e[38:32], 16'h0);
        @(negedge clk100);
        cfg_sel = sel;
        cfg_req = 1'b1;
        @(negedge clk100);
        cfg_req = 1'b0;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            @(negedge clk100);
            cyc++;
        end
        chk("retry_read_seen", exp_q.size(), 0);
        @(negedge clk100);
        cpu_reset = 1'b1;
        @(negedge clk100);
        check_reset_vals("midop");
        exp_q.delete();
        no_drdy = 1'b0;
        exp_cur = 1'b0;
        @(negedge clk100);
        do_boot("reboot");

        // Corrupted readback of the first written register.
        corrupt = 1'b1;
        sel = 1'($urandom_range(0, 1));
        run_cfg(sel, 3);
`ifdef PLL_DRP_READBACK_EN
        chk("corrupt_error_seen", {31'h0, (t_err >= 0)}, 1);
        chk("corrupt_cur_cfg", {31'h0, cur_cfg}, {31'h0, exp_cur});
`else
        exp_cur = sel;
        chk("corrupt_cur_cfg", {31'h0, cur_cfg}, {31'h0, exp_cur});
`endif
        corrupt = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Hard stop in case something above stalls.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 2000000");
        $fatal(1);
    end
endmodule
